// File: rtl/regfile_write_arbiter.sv
// Write-port owner for the 16x16 register file: scrubs all registers to zero after reset
// or on request, then arbitrates ALU (A, preferred) and load (B) writebacks with starvation relief.
module regfile_write_arbiter #(
    parameter int DW         = 16,
    parameter int AW         = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          init_req,
    output logic          init_busy,
    input  logic          a_valid,
    input  logic [AW-1:0] a_reg,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_reg,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    output logic [AW-1:0] DstReg,
    output logic          WriteReg,
    output logic [DW-1:0] DstData
);

    localparam int SW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [AW-1:0] SCNT_LAST = '1;
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic {
        SCRUB,
        RUN
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] scnt;
    logic [AW-1:0] scnt_nxt;
    logic [SW-1:0] starve;
    logic [SW-1:0] starve_nxt;
    logic          b_pri;
    logic          wr_en_nxt;
    logic [AW-1:0] wr_reg_nxt;
    logic [DW-1:0] wr_data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= SCRUB;
            scnt   <= '0;
            starve <= '0;
        end else begin
            state  <= state_nxt;
            scnt   <= scnt_nxt;
            starve <= starve_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        scnt_nxt  = '0;
        case (state)
            SCRUB: begin
                scnt_nxt = scnt + AW'(1);
                if (scnt == SCNT_LAST) begin
                    state_nxt = RUN;
                    scnt_nxt  = '0;
                end
            end
            RUN: begin
                if (init_req) begin
                    state_nxt = SCRUB;
                end
            end
            default: state_nxt = SCRUB;
        endcase
    end

    // Grants are combinational; init_req in RUN suppresses both so the scrub starts clean.
    always_comb begin
        init_busy   = (state == SCRUB);
        b_pri       = (starve == STARVE_TOP);
        a_ready     = 1'b0;
        b_ready     = 1'b0;
        wr_en_nxt   = 1'b0;
        wr_reg_nxt  = DstReg;
        wr_data_nxt = DstData;
        starve_nxt  = starve;
        case (state)
            SCRUB: begin
                wr_en_nxt   = 1'b1;
                wr_reg_nxt  = scnt;
                wr_data_nxt = '0;
            end
            RUN: begin
                if (init_req) begin
                    starve_nxt = '0;
                end else if (b_valid && (!a_valid || b_pri)) begin
                    b_ready     = 1'b1;
                    wr_en_nxt   = 1'b1;
                    wr_reg_nxt  = b_reg;
                    wr_data_nxt = b_data;
                    starve_nxt  = '0;
                end else if (a_valid) begin
                    a_ready     = 1'b1;
                    wr_en_nxt   = 1'b1;
                    wr_reg_nxt  = a_reg;
                    wr_data_nxt = a_data;
                    if (b_valid && !b_pri) begin
                        starve_nxt = starve + SW'(1);
                    end
                end
            end
            default: begin
                wr_en_nxt = 1'b0;
            end
        endcase
    end

    // Registered write port; index/data hold when no write is issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            WriteReg <= 1'b0;
            DstReg   <= '0;
            DstData  <= '0;
        end else begin
            WriteReg <= wr_en_nxt;
            DstReg   <= wr_reg_nxt;
            DstData  <= wr_data_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus pushes expected writes,
// a negedge monitor pops and compares every WriteReg cycle against them.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        init_req;
    logic        init_busy;
    logic        a_valid;
    logic [3:0]  a_reg;
    logic [15:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [3:0]  b_reg;
    logic [15:0] b_data;
    logic        b_ready;
    logic [3:0]  DstReg;
    logic        WriteReg;
    logic [15:0] DstData;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [19:0] exp_q[$];
    logic [15:0] shadow[16];

    always #5 clk = ~clk;

    regfile_write_arbiter #(.DW(16), .AW(4), .STARVE_MAX(3)) dut (
        .clk(clk), .rst(rst), .init_req(init_req), .init_busy(init_busy),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_reg(b_reg), .b_data(b_data), .b_ready(b_ready),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [3:0] ar, input logic [15:0] ad,
                                 input logic bv, input logic [3:0] br, input logic [15:0] bd,
                                 input logic ir);
        a_valid  = av;
        a_reg    = ar;
        a_data   = ad;
        b_valid  = bv;
        b_reg    = br;
        b_data   = bd;
        init_req = ir;
    endtask

    // One cycle: check handshake outputs mid-cycle, record any expected write, advance.
    task automatic stepCheck(input logic exp_a, input logic exp_b, input logic exp_busy, input string tag);
        @(negedge clk);
        checkOutput({tag, " a_ready"}, {31'd0, a_ready}, {31'd0, exp_a});
        checkOutput({tag, " b_ready"}, {31'd0, b_ready}, {31'd0, exp_b});
        checkOutput({tag, " init_busy"}, {31'd0, init_busy}, {31'd0, exp_busy});
        if (exp_a) exp_q.push_back({a_reg, a_data});
        if (exp_b) exp_q.push_back({b_reg, b_data});
        @(posedge clk);
        #1;
    endtask

    task automatic pushScrub(input int count);
        for (int i = 0; i < count; i++) exp_q.push_back({4'(i), 16'h0000});
    endtask

    // Monitor: every write cycle must match the oldest expected write.
    initial begin
        logic [19:0] e;
        forever begin
            @(negedge clk);
            if (WriteReg === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("[TB] FAIL unexpected write: got R%0d=%h, expected no write", DstReg, DstData);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("write DstReg", {28'd0, DstReg}, {28'd0, e[19:16]});
                    checkOutput("write DstData", {16'd0, DstData}, {16'd0, e[15:0]});
                    shadow[DstReg] = DstData;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) shadow[i] = 16'hDEAD;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset WriteReg", {31'd0, WriteReg}, 32'd0);
        checkOutput("reset DstReg", {28'd0, DstReg}, 32'd0);
        checkOutput("reset DstData", {16'd0, DstData}, 32'd0);
        checkOutput("reset init_busy", {31'd0, init_busy}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] power-up scrub");
        pushScrub(16);
        rst = 1'b0;
        applyStimulus(1, 4'd4, 16'hFFFF, 1, 4'd6, 16'hEEEE, 1);
        repeat (16) stepCheck(0, 0, 1, "scrub");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCheck(0, 0, 0, "first run");
        checkOutput("R0 after scrub", {16'd0, shadow[0]}, 32'd0);
        checkOutput("R15 after scrub", {16'd0, shadow[15]}, 32'd0);

        $display("[TB] A only");
        applyStimulus(1, 4'd3, 16'h1234, 0, 0, 0, 0);
        stepCheck(1, 0, 0, "A only");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCheck(0, 0, 0, "idle");
        checkOutput("R3 readback", {16'd0, shadow[3]}, 32'h1234);

        $display("[TB] starvation relief");
        applyStimulus(1, 4'd1, 16'h0A0A, 1, 4'd5, 16'hBEEF, 0);
        for (int r = 0; r < 2; r++) begin
            repeat (3) stepCheck(1, 0, 0, "contend A");
            stepCheck(0, 1, 0, "contend B");
        end
        applyStimulus(0, 0, 0, 1, 4'd6, 16'h6666, 0);
        stepCheck(0, 1, 0, "B only");

        $display("[TB] same register R7");
        applyStimulus(1, 4'd7, 16'h1111, 1, 4'd7, 16'h2222, 0);
        stepCheck(1, 0, 0, "R7 A");
        applyStimulus(0, 0, 0, 1, 4'd7, 16'h2222, 0);
        stepCheck(0, 1, 0, "R7 B");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCheck(0, 0, 0, "idle");
        checkOutput("R7 final", {16'd0, shadow[7]}, 32'h2222);

        $display("[TB] init_req in RUN");
        applyStimulus(1, 4'd9, 16'h9999, 0, 0, 0, 0);
        stepCheck(1, 0, 0, "pre-init A");
        applyStimulus(1, 4'd2, 16'h5555, 0, 0, 0, 1);
        stepCheck(0, 0, 0, "init_req");
        pushScrub(16);
        applyStimulus(1, 4'd2, 16'h5555, 0, 0, 0, 0);
        repeat (16) stepCheck(0, 0, 1, "rescrub");
        stepCheck(1, 0, 0, "post-scrub A");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        stepCheck(0, 0, 0, "idle");
        checkOutput("R2 readback", {16'd0, shadow[2]}, 32'h5555);
        checkOutput("R7 scrubbed", {16'd0, shadow[7]}, 32'd0);
        checkOutput("R9 scrubbed", {16'd0, shadow[9]}, 32'd0);

        $display("[TB] reset mid-scrub");
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        stepCheck(0, 0, 0, "init_req 2");
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        pushScrub(9);
        repeat (9) stepCheck(0, 0, 1, "partial scrub");
        rst = 1'b1;
        stepCheck(0, 0, 1, "rst edge");
        repeat (2) begin
            @(negedge clk);
            checkOutput("rst WriteReg", {31'd0, WriteReg}, 32'd0);
            checkOutput("rst DstReg", {28'd0, DstReg}, 32'd0);
            @(posedge clk);
            #1;
        end
        pushScrub(16);
        rst = 1'b0;
        repeat (16) stepCheck(0, 0, 1, "restart scrub");
        stepCheck(0, 0, 0, "idle");

        for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(negedge clk);
        checkOutput("pending writes", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
